// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges a priority in-order writeback port (A) and a FIFO-buffered
// late-result port (B) onto the register file's single registered write port.
module wb_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [DATA_WIDTH-1:0]        a_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [DATA_WIDTH-1:0]        b_data,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        w_addr,
    output logic [DATA_WIDTH-1:0]        w_data,
    output logic [2**ADDR_WIDTH-1:0]     busy_mask,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr, off;
    logic [SW-1:0]         starve_cnt;
    logic                  a_fire, enq, deq, fifo_empty;

    assign fifo_empty = fifo_count == '0;
    assign b_ready    = fifo_count != CW'(FIFO_DEPTH);
    assign a_ready    = !(starve_cnt == SW'(STARVE_LIMIT) && !fifo_empty);
    assign a_fire     = a_valid && a_ready;
    // Writes to r0 are accepted but dropped, so they never occupy a slot.
    assign enq        = b_valid && b_ready && b_addr != '0;
    assign deq        = !a_fire && !fifo_empty;

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= b_addr;
            q_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
            wr_en      <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
        end else begin
            rd_ptr     <= rd_ptr + PW'(deq);
            wr_ptr     <= wr_ptr + PW'(enq);
            fifo_count <= fifo_count + CW'(enq) - CW'(deq);
            if (a_fire && !fifo_empty)
                starve_cnt <= (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
            else
                starve_cnt <= '0;
            wr_en <= a_fire ? (a_addr != '0) : !fifo_empty;
            if (a_fire && a_addr != '0) begin
                w_addr <= a_addr;
                w_data <= a_data;
            end else if (deq) begin
                w_addr <= q_addr[rd_ptr];
                w_data <= q_data[rd_ptr];
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        off       = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < fifo_count) busy_mask[q_addr[i]] = 1'b1;
        end
        if (wr_en) busy_mask[w_addr] = 1'b1;
        busy_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based reference model of the arbiter.
module tb_wb_write_arbiter;
    localparam int DW = 32, AW = 5, DEPTH = 4, LIMIT = 8;

    logic clk = 0, rst_n = 0;
    logic a_valid = 0, b_valid = 0;
    logic [AW-1:0] a_addr = 0, b_addr = 0;
    logic [DW-1:0] a_data = 0, b_data = 0;
    logic a_ready, b_ready, wr_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [2**AW-1:0] busy_mask;
    logic [$clog2(DEPTH):0] fifo_count;

    wb_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .busy_mask(busy_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} ent_t;
    ent_t mq[$];
    int m_starve = 0;
    logic m_wr_en = 0;
    logic [AW-1:0] m_w_addr = 0;
    logic [DW-1:0] m_w_data = 0;

    function automatic logic m_a_ready();
        return !(m_starve == LIMIT && mq.size() != 0);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] m = 0;
        foreach (mq[i]) m[mq[i].addr] = 1'b1;
        if (m_wr_en) m[m_w_addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_wr_en = 0;
        m_w_addr = 0;
        m_w_data = 0;
    endtask

    task automatic model_step();
        int sz = mq.size();
        bit ag = a_valid && m_a_ready();
        bit bg = b_valid && (sz != DEPTH);
        ent_t e;
        if (ag) begin
            m_wr_en = a_addr != 0;
            if (a_addr != 0) begin
                m_w_addr = a_addr;
                m_w_data = a_data;
            end
            m_starve = (sz == 0) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
        end else if (sz != 0) begin
            e = mq.pop_front();
            m_wr_en = 1;
            m_w_addr = e.addr;
            m_w_data = e.data;
            m_starve = 0;
        end else begin
            m_wr_en = 0;
            m_starve = 0;
        end
        if (bg && b_addr != 0) begin
            e = {b_addr, b_data};
            mq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("wr_en", wr_en, m_wr_en);
            check("w_addr", w_addr, m_w_addr);
            check("w_data", w_data, m_w_data);
            check("fifo_count", fifo_count, mq.size());
            check("busy_mask", busy_mask, m_busy());
            check("a_ready", a_ready, m_a_ready());
            check("b_ready", b_ready, mq.size() != DEPTH);
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
    endtask

    logic [AW-1:0] got[$];
    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        // single A write, then A to r0
        drive(1, 3, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        check("t2_wr_en", wr_en, 1);
        check("t2_w_addr", w_addr, 3);
        check("t2_w_data", w_data, 32'hDEADBEEF);
        drive(1, 0, 32'h1234, 0, 0, 0);
        cycle();
        check("t2_addr0_wr_en", wr_en, 0);
        // fill the FIFO under continuous A traffic, then drain
        for (int i = 1; i <= 5; i++) begin
            drive(1, 10, i, 1, AW'(i), 100 + i);
            if (i == 5) begin
                check("t3_b_ready_full", b_ready, 0);
                check("t3_count_full", fifo_count, 4);
            end
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        got.delete();
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (wr_en) got.push_back(w_addr);
        end
        check("t3_drain_n", got.size(), 4);
        for (int k = 0; k < got.size() && k < 4; k++) check($sformatf("t3_drain%0d", k), got[k], k + 1);
        // starvation bound
        drive(1, 9, 32'h99, 1, 7, 32'h55);
        cycle();
        drive(1, 9, 32'h99, 0, 0, 0);
        n = 0;
        while (a_ready && n < 20) begin
            cycle();
            n++;
        end
        check("t4_a_grants", n, 8);
        cycle();
        check("t4_wr_en", wr_en, 1);
        check("t4_w_addr", w_addr, 7);
        check("t4_w_data", w_data, 32'h55);
        check("t4_a_ready_after", a_ready, 1);
        // busy mask lifetime of a B write
        drive(0, 0, 0, 1, 5, 32'h5A5A);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        check("t5_busy_queued", busy_mask[5], 1);
        cycle();
        check("t5_wr_en", wr_en, 1);
        check("t5_w_addr", w_addr, 5);
        check("t5_busy_out", busy_mask[5], 1);
        cycle();
        check("t5_busy_clear", busy_mask[5], 0);
        // full FIFO refuses B even while dequeuing; B to r0 does not enqueue
        for (int i = 0; i < 4; i++) begin
            drive(1, 11, 32'h11, 1, AW'(12 + i), 200 + i);
            cycle();
        end
        drive(0, 0, 0, 1, 6, 32'h66);
        check("t6_full_count", fifo_count, 4);
        check("t6_full_b_ready", b_ready, 0);
        cycle();
        check("t6_count_after", fifo_count, 3);
        check("t6_b_ready_after", b_ready, 1);
        drive(1, 11, 32'h11, 1, 0, 32'h77);
        check("t6_b0_ready", b_ready, 1);
        cycle();
        check("t6_b0_count", fifo_count, 3);
        // asynchronous reset mid-cycle with entries queued
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) cycle();
        drive(1, 13, 32'h13, 1, 20, 32'h20);
        cycle();
        drive(1, 13, 32'h13, 1, 21, 32'h21);
        cycle();
        check("t1_count_pre", fifo_count, 2);
        #2 rst_n = 0;
        model_reset();
        #1;
        check("t1_wr_en", wr_en, 0);
        check("t1_count", fifo_count, 0);
        check("t1_busy", busy_mask, 0);
        check("t1_b_ready", b_ready, 1);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1;
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 99) < 50, AW'($urandom), $urandom,
                  $urandom_range(0, 99) < 60, AW'($urandom), $urandom);
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
